// File: rtl/rx_gasket_pkg.sv
// Shared gasket constants: MAC width codes, lane helpers,
// the K28.5 COM symbol and the lane-fill FSM states.
package rx_gasket_pkg;

  localparam logic [5:0] WIDTH_8  = 6'd8;
  localparam logic [5:0] WIDTH_16 = 6'd16;
  localparam logic [5:0] WIDTH_32 = 6'd32;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  // Unknown width codes fall back to a byte-wide MAC.
  function automatic logic [2:0] lanes_of(input logic [5:0] w);
    case (w)
      WIDTH_16: return 3'd2;
      WIDTH_32: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd4:    return 32'hFFFF_FFFF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

endpackage

// File: rtl/rx_gasket.sv
// Packs decoded RX symbols into 8/16/32-bit MAC words,
// lane 0 first, with optional realignment on COM.
module rx_gasket
  import rx_gasket_pkg::*;
#(
  parameter bit         ALIGN_ON_COM = 1'b1,
  parameter logic [7:0] COM_SYMBOL   = K28_5
) (
  input  logic        Bit_Rate_CLK_10,
  input  logic        Reset,
  input  logic [5:0]  DataBusWidth,
  input  logic [7:0]  RxData,
  input  logic        RxDataK,
  input  logic        RxValid,
  output logic [31:0] MAC_RX_Data,
  output logic [3:0]  MAC_RX_DataK,
  output logic        MAC_RX_Valid,
  output logic        Partial_Drop
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] asm_q, asm_d;
  logic [3:0]  asmk_q, asmk_d;
  logic [31:0] data_d;
  logic [3:0]  datak_d;
  logic        valid_d, drop_d;
  logic        done, is_com;
  logic [2:0]  n_new;
  logic [31:0] m;

  always_ff @(posedge Bit_Rate_CLK_10 or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      n_q          <= 3'd1;
      asm_q        <= 32'h0;
      asmk_q       <= 4'h0;
      MAC_RX_Data  <= 32'h0;
      MAC_RX_DataK <= 4'h0;
      MAC_RX_Valid <= 1'b0;
      Partial_Drop <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      asm_q        <= asm_d;
      asmk_q       <= asmk_d;
      MAC_RX_Data  <= data_d;
      MAC_RX_DataK <= datak_d;
      MAC_RX_Valid <= valid_d;
      Partial_Drop <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    asm_d   = asm_q;
    asmk_d  = asmk_q;
    data_d  = MAC_RX_Data;
    datak_d = MAC_RX_DataK;
    valid_d = 1'b0;
    drop_d  = 1'b0;
    done    = 1'b0;
    m       = 32'h0;
    n_new   = lanes_of(DataBusWidth);
    is_com  = ALIGN_ON_COM && RxDataK &&
              (RxData == COM_SYMBOL);

    if (RxValid) begin
      if (state_q == IDLE || is_com) begin
        n_d    = n_new;
        asm_d  = {24'h0, RxData};
        asmk_d = {3'b000, RxDataK};
        // A COM that completes a 1-lane word outranks the drop pulse.
        if (n_new == 3'd1) begin
          done = 1'b1;
        end else begin
          cnt_d   = 2'd1;
          state_d = FILL;
          drop_d  = (state_q == FILL);
        end
      end else begin
        asm_d[{cnt_q, 3'b000} +: 8] = RxData;
        asmk_d[cnt_q]               = RxDataK;
        if ({1'b0, cnt_q} == n_q - 3'd1)
          done = 1'b1;
        else
          cnt_d = cnt_q + 2'd1;
      end
    end else if (state_q == FILL) begin
      drop_d  = 1'b1;
      cnt_d   = 2'd0;
      state_d = IDLE;
      asm_d   = 32'h0;
      asmk_d  = 4'h0;
    end

    if (done) begin
      m       = lane_mask(n_d);
      data_d  = asm_d & m;
      datak_d = asmk_d & {m[24], m[16], m[8], m[0]};
      valid_d = 1'b1;
      cnt_d   = 2'd0;
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_rx_gasket.sv
// Scoreboard bench for rx_gasket: directed plan cases
// followed by randomized traffic against a queue model.
module tb_rx_gasket;

  logic        clk;
  logic        Reset;
  logic [5:0]  DataBusWidth;
  logic [7:0]  RxData;
  logic        RxDataK;
  logic        RxValid;
  logic [31:0] MAC_RX_Data;
  logic [3:0]  MAC_RX_DataK;
  logic        MAC_RX_Valid;
  logic        Partial_Drop;

  rx_gasket dut (
    .Bit_Rate_CLK_10(clk),
    .Reset(Reset),
    .DataBusWidth(DataBusWidth),
    .RxData(RxData),
    .RxDataK(RxDataK),
    .RxValid(RxValid),
    .MAC_RX_Data(MAC_RX_Data),
    .MAC_RX_DataK(MAC_RX_DataK),
    .MAC_RX_Valid(MAC_RX_Valid),
    .Partial_Drop(Partial_Drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          word;
    logic [31:0] d;
    logic [3:0]  k;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  mb[$];
  bit          mk[$];
  int          mn = 1;
  logic [31:0] last_d = 32'h0;
  logic [3:0]  last_k = 4'h0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name,
                     input logic [35:0] got,
                     input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic emit_word();
    ev_t e;
    e.word = 1'b1;
    e.d = 32'h0;
    e.k = 4'h0;
    for (int i = 0; i < mb.size(); i++) begin
      e.d = e.d | (32'(mb[i]) << (8 * i));
      e.k = e.k | (4'(mk[i]) << i);
    end
    exp_q.push_back(e);
    mb.delete();
    mk.delete();
  endtask

  task automatic emit_drop();
    ev_t e;
    e.word = 1'b0;
    e.d = 32'h0;
    e.k = 4'h0;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input bit k,
                      input bit v, input logic [5:0] w);
    bit com;
    bit had;
    @(negedge clk);
    RxData = d;
    RxDataK = k;
    RxValid = v;
    DataBusWidth = w;
    com = k && (d == 8'hBC);
    if (v) begin
      if (mb.size() == 0 || com) begin
        had = (mb.size() != 0);
        mb.delete();
        mk.delete();
        mn = (w == 6'd16) ? 2 : (w == 6'd32) ? 4 : 1;
        mb.push_back(d);
        mk.push_back(k);
        if (mb.size() == mn) emit_word();
        else if (had) emit_drop();
      end else begin
        mb.push_back(d);
        mk.push_back(k);
        if (mb.size() == mn) emit_word();
      end
    end else if (mb.size() != 0) begin
      emit_drop();
      mb.delete();
      mk.delete();
    end
  endtask

  task automatic model_reset();
    mb.delete();
    mk.delete();
    exp_q.delete();
    mn = 1;
    last_d = 32'h0;
    last_k = 4'h0;
  endtask

  task automatic check_rst();
    chk("rst_data", {MAC_RX_DataK, MAC_RX_Data}, 36'h0);
    chk("rst_flags", {34'h0, MAC_RX_Valid, Partial_Drop}, 36'h0);
  endtask

  // Monitor: every cycle, DUT strobes must match the expected queue.
  initial begin
    ev_t e;
    bit  got_any, exp_any;
    forever begin
      @(posedge clk);
      #1;
      if (!Reset) begin
        got_any = MAC_RX_Valid | Partial_Drop;
        exp_any = (exp_q.size() != 0);
        chk("exclusive", {35'h0, MAC_RX_Valid & Partial_Drop}, 36'h0);
        chk("strobe_present", {35'h0, got_any}, {35'h0, exp_any});
        if (exp_any) begin
          e = exp_q.pop_front();
          if (got_any) begin
            chk("strobe_kind", {34'h0, MAC_RX_Valid, Partial_Drop},
                {34'h0, e.word, !e.word});
            if (e.word) begin
              chk("word", {MAC_RX_DataK, MAC_RX_Data}, {e.k, e.d});
              last_d = e.d;
              last_k = e.k;
            end
          end
        end else if (!MAC_RX_Valid) begin
          chk("hold", {MAC_RX_DataK, MAC_RX_Data}, {last_k, last_d});
        end
      end
    end
  end

  initial begin
    logic [5:0] w;
    int         p;
    bit         v, k;
    logic [7:0] d;

    Reset = 1'b1;
    DataBusWidth = 6'd8;
    RxData = 8'h0;
    RxDataK = 1'b0;
    RxValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_rst();
    @(negedge clk);
    Reset = 1'b0;

    // Byte-wide: back-to-back strobes.
    send(8'h64, 0, 1, 6'd8);
    send(8'hC8, 1, 1, 6'd8);
    send(8'h00, 0, 0, 6'd8);
    chk("plan_w8", {MAC_RX_DataK, MAC_RX_Data}, {4'h1, 32'h000000C8});

    // 16-bit word, then held with Valid low.
    send(8'h26, 1, 1, 6'd16);
    send(8'h02, 0, 1, 6'd16);
    send(8'h00, 0, 0, 6'd16);
    send(8'h00, 0, 0, 6'd16);
    chk("plan_w16", {MAC_RX_DataK, MAC_RX_Data}, {4'h1, 32'h00000226});

    // Width change mid-word is ignored.
    send(8'hE8, 0, 1, 6'd32);
    send(8'h07, 0, 1, 6'd32);
    send(8'h00, 0, 1, 6'd16);
    send(8'h00, 0, 1, 6'd16);
    send(8'h00, 0, 0, 6'd16);
    chk("plan_w32", {MAC_RX_DataK, MAC_RX_Data}, {4'h0, 32'h000007E8});

    // Abort then full word.
    send(8'h11, 0, 1, 6'd32);
    send(8'h22, 0, 1, 6'd32);
    send(8'h00, 0, 0, 6'd32);
    send(8'hAA, 0, 1, 6'd32);
    send(8'hBB, 0, 1, 6'd32);
    send(8'hCC, 0, 1, 6'd32);
    send(8'hDD, 0, 1, 6'd32);
    send(8'h00, 0, 0, 6'd32);
    chk("plan_abort", {MAC_RX_DataK, MAC_RX_Data}, {4'h0, 32'hDDCCBBAA});

    // COM realignment mid-word.
    send(8'h11, 0, 1, 6'd32);
    send(8'h22, 0, 1, 6'd32);
    send(8'hBC, 1, 1, 6'd32);
    send(8'h33, 0, 1, 6'd32);
    send(8'h44, 0, 1, 6'd32);
    send(8'h55, 0, 1, 6'd32);
    send(8'h00, 0, 0, 6'd32);
    chk("plan_com", {MAC_RX_DataK, MAC_RX_Data}, {4'h1, 32'h554433BC});

    // Asynchronous reset mid-word.
    send(8'h11, 0, 1, 6'd32);
    send(8'h22, 0, 1, 6'd32);
    @(posedge clk);
    #2;
    Reset = 1'b1;
    #1;
    check_rst();
    model_reset();
    @(negedge clk);
    Reset = 1'b0;
    RxValid = 1'b0;
    send(8'h01, 0, 1, 6'd32);
    send(8'h02, 1, 1, 6'd32);
    send(8'h03, 0, 1, 6'd32);
    send(8'h04, 0, 1, 6'd32);
    send(8'h00, 0, 0, 6'd32);
    chk("plan_reset", {MAC_RX_DataK, MAC_RX_Data}, {4'h2, 32'h04030201});

    // Randomized traffic.
    w = 6'd32;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        p = $urandom_range(0, 4);
        w = (p == 0) ? 6'd8 : (p == 1) ? 6'd16 :
            (p == 2) ? 6'd32 : (p == 3) ? 6'd5 : 6'd0;
      end
      v = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) begin
        d = 8'hBC;
        k = 1'b1;
      end else begin
        d = 8'($urandom);
        k = ($urandom_range(0, 7) == 0);
      end
      send(d, k, v, w);
    end
    repeat (4) send(8'h00, 0, 0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
